mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like memory port between instruction fetch (F stage) and data access (M stage).
- Sequences one outstanding transaction at a time: grant, then address phase, then data phase.
- Produces the imem_busy and dmem_busy indications that the pipeline hazard unit consumes as stall sources.
- Holds completed results until the owning pipeline stage advances, so that no request is issued twice.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_req_slot.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } arb_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_req_slot.sv
// rtl/mem_port_arbiter_req_slot.sv - per-requester done/rdata/discard state and busy logic
module arb_req_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic              i_cancel,
    input  logic              i_adv,
    input  logic              i_inflight,
    input  logic              i_complete,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_eligible
);

    logic              r_done;
    logic              r_discard;
    logic [DATA_W-1:0] r_rdata;
    logic              w_drop;
    logic              w_accept;

    // A cancel arriving in the completion cycle drops the result just like an earlier one.
    assign w_drop     = r_discard | i_cancel;
    assign w_accept   = i_complete & ~w_drop;

    assign o_rdata    = w_accept ? i_mem_rdata : r_rdata;
    assign o_busy     = i_req & ~r_done & ~w_accept;
    assign o_eligible = i_req & ~r_done & ~i_cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_done    <= 1'b0;
            r_discard <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_rdata <= i_mem_rdata;
            end
            // The stage consuming the result in the completion cycle leaves nothing to hold.
            if (i_adv || i_cancel) begin
                r_done <= 1'b0;
            end else if (w_accept) begin
                r_done <= 1'b1;
            end
            if (i_complete) begin
                r_discard <= 1'b0;
            end else if (i_cancel && i_inflight) begin
                r_discard <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like port between fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit D_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_busy,
    input  logic              i_cancel,
    input  logic              f_adv,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_busy,
    input  logic              m_adv,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_grant_inst;
    logic w_grant_data;
    logic w_complete;
    logic w_i_elig;
    logic w_d_elig;
    logic w_i_inflight;
    logic w_d_inflight;

    assign w_complete   = ((r_state == ST_ADDR) && m_addr_ok && m_data_ok) ||
                          ((r_state == ST_DATA) && m_data_ok);
    assign w_i_inflight = (r_owner == OWN_INST) && (r_state != ST_IDLE);
    assign w_d_inflight = (r_owner == OWN_DATA) && (r_state != ST_IDLE);

    assign m_req   = (r_state == ST_ADDR);
    assign m_wr    = r_wr;
    assign m_size  = r_size;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_elig && (D_PRIO || !w_i_elig)) begin
                    w_grant_data = 1'b1;
                end else if (w_i_elig) begin
                    w_grant_inst = 1'b1;
                end
                if (w_grant_data || w_grant_inst) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    w_state_nxt = m_data_ok ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_wr    <= 1'b0;
            r_size  <= SIZE_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_data) begin
                r_owner <= OWN_DATA;
                r_wr    <= d_wr;
                r_size  <= d_size;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_grant_inst) begin
                r_owner <= OWN_INST;
                r_wr    <= 1'b0;
                r_size  <= SIZE_WORD;
                r_addr  <= i_addr;
                r_wdata <= '0;
            end else if (w_complete) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    arb_req_slot #(.DATA_W(DATA_W)) u_inst_slot (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (i_req),
        .i_cancel    (i_cancel),
        .i_adv       (f_adv),
        .i_inflight  (w_i_inflight),
        .i_complete  (w_complete && (r_owner == OWN_INST)),
        .i_mem_rdata (m_rdata),
        .o_rdata     (i_rdata),
        .o_busy      (i_busy),
        .o_eligible  (w_i_elig)
    );

    // The data side is never flushed while in flight, so its cancel is tied off.
    arb_req_slot #(.DATA_W(DATA_W)) u_data_slot (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (d_req),
        .i_cancel    (1'b0),
        .i_adv       (m_adv),
        .i_inflight  (w_d_inflight),
        .i_complete  (w_complete && (r_owner == OWN_DATA)),
        .i_mem_rdata (m_rdata),
        .o_rdata     (d_rdata),
        .o_busy      (d_busy),
        .o_eligible  (w_d_elig)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_cancel, f_adv;
    logic [31:0] i_addr, i_rdata;
    logic        i_busy;
    logic        d_req, d_wr, d_busy, m_adv;
    logic [1:0]  d_size, m_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1'b1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_busy    (i_busy),
        .i_cancel  (i_cancel),
        .f_adv     (f_adv),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_busy    (d_busy),
        .m_adv     (m_adv),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        f_adv     = 1'b0;
        m_adv     = 1'b0;
        i_cancel  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        i_req = 0; i_addr = 0; i_cancel = 0; f_adv = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0; m_adv = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        #12;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_size", m_size, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_i_busy", i_busy, 0);
        chk("rst_d_busy", d_busy, 0);
        resetn = 1'b1;
        tick();

        // single fetch
        i_req = 1; i_addr = 32'hBFC00000; #1;
        chk("f0_busy", i_busy, 1);
        chk("f0_m_req", m_req, 0);
        tick(); #1;
        chk("f1_busy", i_busy, 1);
        chk("f1_m_req", m_req, 1);
        chk("f1_m_addr", m_addr, 32'hBFC00000);
        chk("f1_m_wr", m_wr, 0);
        chk("f1_m_size", m_size, 2);
        tick(); m_addr_ok = 1; #1;
        chk("f2_busy", i_busy, 1);
        chk("f2_m_req", m_req, 1);
        chk("f2_m_addr", m_addr, 32'hBFC00000);
        tick(); m_data_ok = 1; m_rdata = 32'h24080001; #1;
        chk("f3_m_req", m_req, 0);
        chk("f3_busy", i_busy, 0);
        chk("f3_rdata", i_rdata, 32'h24080001);

        // held result while F stalls
        for (int k = 0; k < 3; k++) begin
            tick(); m_rdata = 32'h0; #1;
            chk("hold_m_req", m_req, 0);
            chk("hold_busy", i_busy, 0);
            chk("hold_rdata", i_rdata, 32'h24080001);
        end
        tick(); f_adv = 1; i_addr = 32'hBFC00004; #1;
        chk("adv_busy", i_busy, 0);
        tick(); #1;
        chk("adv1_busy", i_busy, 1);
        chk("adv1_m_req", m_req, 0);
        tick(); m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h11111111; f_adv = 1; #1;
        chk("f4_m_req", m_req, 1);
        chk("f4_m_addr", m_addr, 32'hBFC00004);
        chk("f4_busy", i_busy, 0);
        chk("f4_rdata", i_rdata, 32'h11111111);
        tick(); i_req = 0; #1;
        chk("f4_idle_m_req", m_req, 0);

        // simultaneous requests, data has priority
        i_req = 1; i_addr = 32'hBFC00008;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80000010; #1;
        chk("s0_i_busy", i_busy, 1);
        chk("s0_d_busy", d_busy, 1);
        tick(); m_addr_ok = 1; #1;
        chk("s1_m_req", m_req, 1);
        chk("s1_m_addr", m_addr, 32'h80000010);
        chk("s1_m_wr", m_wr, 0);
        tick(); m_data_ok = 1; m_rdata = 32'h0000CAFE; m_adv = 1; #1;
        chk("s2_m_req", m_req, 0);
        chk("s2_d_busy", d_busy, 0);
        chk("s2_d_rdata", d_rdata, 32'h0000CAFE);
        chk("s2_i_busy", i_busy, 1);
        tick(); d_req = 0; #1;
        chk("s3_m_req", m_req, 0);
        chk("s3_i_busy", i_busy, 1);
        tick(); m_addr_ok = 1; #1;
        chk("s4_m_req", m_req, 1);
        chk("s4_m_addr", m_addr, 32'hBFC00008);

        // cancel while in DATA
        tick(); i_cancel = 1; #1;
        chk("c0_m_req", m_req, 0);
        chk("c0_busy", i_busy, 1);
        tick(); i_addr = 32'hBFC00380; m_data_ok = 1; m_rdata = 32'hDEADBEEF; #1;
        chk("c1_busy", i_busy, 1);
        chk("c1_rdata", i_rdata, 32'h11111111);
        tick(); #1;
        chk("c2_m_req", m_req, 0);
        chk("c2_busy", i_busy, 1);
        chk("c2_rdata", i_rdata, 32'h11111111);
        tick(); m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h3C1A0000; f_adv = 1; #1;
        chk("c3_m_req", m_req, 1);
        chk("c3_m_addr", m_addr, 32'hBFC00380);
        chk("c3_rdata", i_rdata, 32'h3C1A0000);
        tick(); i_req = 0; #1;
        chk("c4_m_req", m_req, 0);

        // store with combined handshake, M stalled afterwards
        d_req = 1; d_wr = 1; d_size = 0; d_addr = 32'h80000020; d_wdata = 32'h000000AA; #1;
        chk("w0_d_busy", d_busy, 1);
        tick(); m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0; #1;
        chk("w1_m_req", m_req, 1);
        chk("w1_m_wr", m_wr, 1);
        chk("w1_m_size", m_size, 0);
        chk("w1_m_addr", m_addr, 32'h80000020);
        chk("w1_m_wdata", m_wdata, 32'h000000AA);
        chk("w1_d_busy", d_busy, 0);
        tick(); i_req = 1; i_addr = 32'hBFC00010; #1;
        chk("w2_m_req", m_req, 0);
        chk("w2_d_busy", d_busy, 0);

        // async reset while a fetch sits in ADDR
        tick(); #1;
        chk("r0_m_req", m_req, 1);
        chk("r0_m_addr", m_addr, 32'hBFC00010);
        resetn = 0; #1;
        chk("r1_m_req", m_req, 0);
        chk("r1_m_addr", m_addr, 0);
        chk("r1_d_busy", d_busy, 1);
        chk("r1_i_busy", i_busy, 1);
        #1;
        resetn = 1; i_req = 0; d_req = 0;
        tick(); #1;
        chk("r2_m_req", m_req, 0);
        chk("r2_d_busy", d_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
